addsub4_selftest: RTL and testbench

- Hardware stimulus generator and response checker for the 4-bit adder/subtractor (AddSub4).
- Drives every operand/mode combination into the DUT ports and samples the DUT's combinational {cout, sum} response. Compares that response against an internal golden model and reports the pass/fail count.
- Sits beside an AddSub4 instance on the lab board, or in a simulation top. It replaces hand-written stimulus with an exhaustive on-chip sweep.

---
 rtl/addsub4_pkg.sv | 27 ++
 rtl/addsub4_selftest_if.sv | 13 +
 rtl/addsub4_ref_model.sv | 11 +
 rtl/addsub4_selftest.sv | 135 +++++++++++++
 tb/tb_addsub4_selftest.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub4_pkg.sv
// Shared definitions for the AddSub4 self-test: sweep sizing, FSM encoding and
// the golden adder/subtractor function.
package addsub4_pkg;

  localparam int unsigned VEC_W   = 9;
  localparam int unsigned NUM_VEC = 512;
  localparam int unsigned ERR_W   = 10;

  localparam logic [VEC_W-1:0] LAST_VEC = 9'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DRIVE = 2'd1;
  localparam state_t ST_CHECK = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Returns {cout, sum}; subtract is a + ~b + 1, so cout=1 means no borrow (a >= b).
  function automatic logic [4:0] addsub4_ref(input logic [3:0] a, input logic [3:0] b,
                                             input logic sel);
    logic [4:0] r;
    if (sel) r = {1'b0, a} + {1'b0, ~b} + 5'd1;
    else     r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

endpackage

// File: rtl/addsub4_selftest_if.sv
// Operand/response bus between the self-test engine and the AddSub4 under test.
interface addsub4_selftest_if;
  logic [3:0] dut_a;
  logic [3:0] dut_b;
  logic       dut_sel;
  logic       dut_cout;
  logic [3:0] dut_sum;

  // Self-test side: drives operands, samples the response.
  modport master (output dut_a, dut_b, dut_sel, input dut_cout, dut_sum);
  // AddSub4 side.
  modport slave (input dut_a, dut_b, dut_sel, output dut_cout, dut_sum);
endinterface

// File: rtl/addsub4_ref_model.sv
// Combinational golden model: expected {cout, sum} for a packed {sel, a, b} vector.
module addsub4_ref_model
  import addsub4_pkg::*;
(
  input  logic [VEC_W-1:0] vec_i,
  output logic [4:0]       exp_o
);

  assign exp_o = addsub4_ref(vec_i[7:4], vec_i[3:0], vec_i[8]);

endmodule

// File: rtl/addsub4_selftest.sv
// Exhaustive on-chip sweep of an AddSub4: drives all 512 {sel, a, b} vectors,
// holds each for SETTLE_CYCLES, compares the response with the golden model
// and reports the mismatch count and first failing vector.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// DRIVE | current vector on the bus, settle timer running
// CHECK | response sampled and compared, advance or finish
// DONE  | results held until start or reset
module addsub4_selftest
  import addsub4_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  addsub4_selftest_if.master  dut,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic                first_fail_valid,
  output logic [VEC_W-1:0]    first_fail_vec
);

  localparam logic [3:0] HOLD_INIT = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q;
  logic [3:0]       hold_q;
  logic [ERR_W-1:0] err_q;
  logic             ffv_q;
  logic [VEC_W-1:0] ffvec_q;
  logic             busy_q, done_q, pass_q;

  logic [4:0] exp_w;
  logic       load_sweep, hold_expired, mismatch, last_vec, enter_drive;

  addsub4_ref_model u_ref (
    .vec_i (vec_q),
    .exp_o (exp_w)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_DRIVE;
      ST_DRIVE: if (hold_expired) state_d = ST_CHECK;
      ST_CHECK: begin
        if ((mismatch && STOP_ON_FAIL) || last_vec) state_d = ST_DONE;
        else                                        state_d = ST_DRIVE;
      end
      ST_DONE:  if (start) state_d = ST_DRIVE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM output decode: strobes steering the datapath registers.
  always_comb begin
    load_sweep   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
    hold_expired = (state_q == ST_DRIVE) && (hold_q == 4'd0);
    mismatch     = (state_q == ST_CHECK) && ({dut.dut_cout, dut.dut_sum} != exp_w);
    last_vec     = (vec_q == LAST_VEC);
    enter_drive  = (state_d == ST_DRIVE) && (state_q != ST_DRIVE);
  end

  // Vector index and settle down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q  <= '0;
      hold_q <= '0;
    end else begin
      if (load_sweep)                                          vec_q <= '0;
      else if ((state_q == ST_CHECK) && (state_d == ST_DRIVE)) vec_q <= vec_q + 9'd1;
      if (enter_drive)                              hold_q <= HOLD_INIT;
      else if ((state_q == ST_DRIVE) && !hold_expired) hold_q <= hold_q - 4'd1;
    end
  end

  // Mismatch counting and first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else if (load_sweep) begin
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else if (mismatch) begin
      if (err_q != ERR_MAX) err_q <= err_q + 10'd1;
      if (!ffv_q) begin
        ffv_q   <= 1'b1;
        ffvec_q <= vec_q;
      end
    end
  end

  // Status flags; done/pass publish one cycle after entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else if (load_sweep) begin
      busy_q <= 1'b1;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else if (state_q == ST_DONE) begin
      busy_q <= 1'b0;
      done_q <= 1'b1;
      pass_q <= (err_q == '0);
    end
  end

  assign dut.dut_sel      = vec_q[8];
  assign dut.dut_a        = vec_q[7:4];
  assign dut.dut_b        = vec_q[3:0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_addsub4_selftest.sv
module tb_addsub4_selftest;
  import addsub4_pkg::*;

  localparam int S0 = 1;
  localparam int S1 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Fault selection for the behavioural AddSub4: 0 good, 1 cout stuck 0,
  // 2 subtract sum +1, 3 sum bit 0 flipped on three chosen vectors.
  logic [1:0] fault_mode = 2'd0;
  logic [8:0] fv0 = '0, fv1 = '0, fv2 = '0;

  addsub4_selftest_if bus0 ();
  addsub4_selftest_if bus1 ();

  logic       busy0, done0, pass0, ffv0;
  logic [9:0] err0;
  logic [8:0] ffvec0;
  logic       busy1, done1, pass1, ffv1;
  logic [9:0] err1;
  logic [8:0] ffvec1;

  addsub4_selftest #(.SETTLE_CYCLES(S0), .STOP_ON_FAIL(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .dut(bus0.master),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_valid(ffv0), .first_fail_vec(ffvec0));

  addsub4_selftest #(.SETTLE_CYCLES(S1), .STOP_ON_FAIL(1'b1)) u_dut_stop (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut(bus1.master),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1));

  // Arithmetic view of a correct AddSub4: subtract gives a-b mod 16, cout = no borrow.
  function automatic int golden(input int sel, input int a, input int b);
    if (sel == 0) return a + b;
    return ((a >= b) ? 16 : 0) + ((a - b + 16) % 16);
  endfunction

  function automatic logic [4:0] faulty(input logic [1:0] mode, input logic [8:0] f0,
                                        input logic [8:0] f1, input logic [8:0] f2,
                                        input logic sel, input logic [3:0] a,
                                        input logic [3:0] b);
    logic [4:0] r;
    logic [8:0] v;
    r = 5'(golden(int'(sel), int'(a), int'(b)));
    v = {sel, a, b};
    case (mode)
      2'd1: r[4] = 1'b0;
      2'd2: if (sel) r[3:0] = r[3:0] + 4'd1;
      2'd3: if (v == f0 || v == f1 || v == f2) r[0] = ~r[0];
      default: ;
    endcase
    return r;
  endfunction

  assign {bus0.dut_cout, bus0.dut_sum} =
    faulty(fault_mode, fv0, fv1, fv2, bus0.dut_sel, bus0.dut_a, bus0.dut_b);
  assign {bus1.dut_cout, bus1.dut_sum} =
    faulty(fault_mode, fv0, fv1, fv2, bus1.dut_sel, bus1.dut_a, bus1.dut_b);

  // Scoreboard over the whole sweep for the currently selected fault.
  task automatic expect_sweep(output int n_err, output int first);
    n_err = 0;
    first = -1;
    for (int v = 0; v < 512; v++) begin
      logic [8:0] vv;
      vv = 9'(v);
      if (int'(faulty(fault_mode, fv0, fv1, fv2, vv[8], vv[7:4], vv[3:0])) !=
          golden(int'(vv[8]), int'(vv[7:4]), int'(vv[3:0]))) begin
        n_err++;
        if (first < 0) first = v;
      end
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulses start on one instance and counts edges until done; -1 on timeout.
  // A second start is pulsed at edge busy_kick (if > 0) to probe the busy guard.
  task automatic run_sweep(input int inst, input int busy_kick, output int edges);
    logic d;
    @(negedge clk);
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    edges = -1;
    for (int e = 1; e <= 3000; e++) begin
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      d = (inst == 0) ? done0 : done1;
      if (d) begin
        edges = e;
        break;
      end
      if (e == busy_kick) begin
        if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
      end
    end
  endtask

  int edges, n_err, first, wait_n;

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_pass", int'(pass0), 0);
    check("rst_err", int'(err0), 0);
    check("rst_ffv", int'(ffv0), 0);
    check("rst_ffvec", int'(ffvec0), 0);
    check("rst_bus", int'({bus0.dut_sel, bus0.dut_a, bus0.dut_b}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Golden spot check: 5 - 1 = 4, no borrow.
    check("spot_5m1", int'(addsub4_ref(4'd5, 4'd1, 1'b1)), golden(1, 5, 1));

    // Correct AddSub4, full sweep.
    fault_mode = 2'd0;
    run_sweep(0, 0, edges);
    check("good_edges", edges, 512 * (S0 + 1) + 1);
    check("good_err", int'(err0), 0);
    check("good_pass", int'(pass0), 1);
    check("good_ffv", int'(ffv0), 0);
    check("good_busy", int'(busy0), 0);

    // cout stuck at 0.
    fault_mode = 2'd1;
    expect_sweep(n_err, first);
    run_sweep(0, 0, edges);
    check("cout0_err", int'(err0), n_err);
    check("cout0_pass", int'(pass0), 0);
    check("cout0_ffv", int'(ffv0), 1);
    check("cout0_ffvec", int'(ffvec0), first);
    check("cout0_hold_bus", int'({bus0.dut_sel, bus0.dut_a, bus0.dut_b}), 511);

    // Restart from DONE clears the report and sweeps again.
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    check("restart_done", int'(done0), 0);
    check("restart_busy", int'(busy0), 1);
    check("restart_err", int'(err0), 0);
    check("restart_ffv", int'(ffv0), 0);
    wait_n = 0;
    while (!done0 && wait_n < 3000) begin
      @(posedge clk);
      #1;
      wait_n++;
    end
    check("restart_edges", wait_n, 512 * (S0 + 1) + 1);
    check("restart_err_end", int'(err0), n_err);

    // Stop-on-fail instance with the same fault.
    run_sweep(1, 0, edges);
    check("stop_edges", edges, (first + 1) * (S1 + 1) + 1);
    check("stop_err", int'(err1), 1);
    check("stop_ffvec", int'(ffvec1), first);
    check("stop_dut_a", int'(bus1.dut_a), (first >> 4) & 15);
    check("stop_dut_b", int'(bus1.dut_b), first & 15);
    check("stop_pass", int'(pass1), 0);

    // Subtract result off by one.
    fault_mode = 2'd2;
    expect_sweep(n_err, first);
    run_sweep(0, 0, edges);
    check("subp1_err", int'(err0), n_err);
    check("subp1_ffvec", int'(ffvec0), first);

    // Random sparse faults, both instances.
    fault_mode = 2'd3;
    for (int it = 0; it < 3; it++) begin
      fv0 = 9'($urandom_range(0, 511));
      fv1 = 9'($urandom_range(0, 511));
      fv2 = 9'($urandom_range(0, 511));
      expect_sweep(n_err, first);
      run_sweep(0, 0, edges);
      check("rnd_err", int'(err0), n_err);
      check("rnd_ffvec", int'(ffvec0), first);
      check("rnd_pass", int'(pass0), 0);
      run_sweep(1, 0, edges);
      check("rnd_stop_edges", edges, (first + 1) * (S1 + 1) + 1);
      check("rnd_stop_ffvec", int'(ffvec1), first);
    end

    // start while busy is ignored.
    fault_mode = 2'd0;
    run_sweep(0, int'($urandom_range(5, 900)), edges);
    check("busy_kick_edges", edges, 512 * (S0 + 1) + 1);
    check("busy_kick_pass", int'(pass0), 1);

    // Async reset mid-sweep, then a clean sweep.
    fault_mode = 2'd1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (390 + $urandom_range(0, 20)) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy0), 0);
    check("midrst_err", int'(err0), 0);
    check("midrst_ffv", int'(ffv0), 0);
    check("midrst_bus", int'({bus0.dut_sel, bus0.dut_a, bus0.dut_b}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    fault_mode = 2'd0;
    run_sweep(0, 0, edges);
    check("postrst_edges", edges, 512 * (S0 + 1) + 1);
    check("postrst_pass", int'(pass0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
